fib_seq_gen: RTL and testbench

Parametrised recurrence-sequence engine, successor to the team's `fibonacci` FSM. It computes the n-th term of a second-order (Fibonacci/Lucas-style) or third-order (Tribonacci) additive recurrence from caller-supplied seeds. It is generalised in data width, maximum order and recurrence mode, and adds busy indication, order-range checking and a defined overflow stop. It sits behind the same load/clear/done control style used by the existing `fib_num_test` stimulus.

---
 rtl/fib_pkg.sv | 23 ++
 rtl/fib_sum3.sv | 30 +++
 rtl/fib_seq_gen.sv | 151 +++++++++++++++
 tb/tb_fib_seq_gen.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/fib_pkg.sv
// Shared types and constants for the recurrence-sequence engine.
//   mode_t  : recurrence selector as seen on the mode input
//   state_t : control FSM states
//   K2, K3  : window depth of the 2-term and 3-term recurrences
package fib_pkg;

  typedef enum logic [1:0] {
    MODE_FIB2  = 2'b00,
    MODE_FIB3  = 2'b01,
    MODE_RSVD2 = 2'b10,
    MODE_RSVD3 = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int unsigned K2 = 2;
  localparam int unsigned K3 = 3;

endpackage

// File: rtl/fib_sum3.sv
// Combinational three-operand unsigned adder with overflow flag.
//   a, b, c : operands (c is dropped unless mode is MODE_FIB3)
//   mode    : recurrence mode
//   sum     : low WIDTH bits of the sum
//   ovf     : sum did not fit in WIDTH bits
module fib_sum3
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  mode_t            mode,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  // Two guard bits cover the worst case of three full-scale operands.
  logic [WIDTH+1:0] wide;
  logic [WIDTH+1:0] c_ext;

  always_comb begin
    c_ext = (mode == MODE_FIB3) ? {2'b00, c} : '0;
    wide  = {2'b00, a} + {2'b00, b} + c_ext;
    sum   = wide[WIDTH-1:0];
    ovf   = |wide[WIDTH+1:WIDTH];
  end

endmodule

// File: rtl/fib_seq_gen.sv
// n-th term of a 2-term or 3-term additive recurrence from caller seeds.
//   clk, reset  : clock and synchronous active-high reset
//   clear       : synchronous abort to IDLE, all outputs zeroed
//   load        : start strobe; mode/seeds/order sampled with it
//   mode        : 00 = 2-term, 01 = 3-term, others rejected
//   data_in_0..2: seeds x[0], x[1], x[2]
//   order       : requested index n (<= MAX_ORDER)
//   data_out    : result term; done: result valid; busy: computing
//   overflw     : stopped on overflow; error: one-cycle request-rejected pulse
module fib_seq_gen
  import fib_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned ORDER_WIDTH = 16,
  parameter int unsigned MAX_ORDER   = 1000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clear,
  input  logic                   load,
  input  logic [1:0]             mode,
  input  logic [DATA_WIDTH-1:0]  data_in_0,
  input  logic [DATA_WIDTH-1:0]  data_in_1,
  input  logic [DATA_WIDTH-1:0]  data_in_2,
  input  logic [ORDER_WIDTH-1:0] order,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   done,
  output logic                   busy,
  output logic                   overflw,
  output logic                   error
);

  localparam logic [ORDER_WIDTH-1:0] MaxOrder = ORDER_WIDTH'(MAX_ORDER);
  localparam logic [ORDER_WIDTH-1:0] Start2   = ORDER_WIDTH'(K2 - 1);
  localparam logic [ORDER_WIDTH-1:0] Start3   = ORDER_WIDTH'(K3 - 1);

  state_t                 state_q;
  mode_t                  mode_q;
  logic [ORDER_WIDTH-1:0] idx_q, n_q;
  // Window: win2_q = x[idx], win1_q = x[idx-1], win0_q = x[idx-2].
  logic [DATA_WIDTH-1:0]  win0_q, win1_q, win2_q;
  logic [DATA_WIDTH-1:0]  data_out_q;
  logic                   done_q, busy_q, overflw_q, error_q;

  mode_t                  req_mode;
  logic                   req_valid;
  logic                   finish;
  logic [1:0]             back;
  logic [DATA_WIDTH-1:0]  sel_term;
  logic [DATA_WIDTH-1:0]  sum;
  logic                   sum_ovf;

  fib_sum3 #(
    .WIDTH(DATA_WIDTH)
  ) u_sum3 (
    .a   (win2_q),
    .b   (win1_q),
    .c   (win0_q),
    .mode(mode_q),
    .sum (sum),
    .ovf (sum_ovf)
  );

  always_comb begin
    req_mode  = mode_t'(mode);
    req_valid = ((req_mode == MODE_FIB2) || (req_mode == MODE_FIB3)) && (order <= MaxOrder);
    // Finished once the window's newest index has reached n. For n < K this
    // is true on the first RUN cycle and the term is picked from the seeds.
    finish    = (n_q <= idx_q);
    back      = 2'(idx_q - n_q);
    unique case (back)
      2'd0:    sel_term = win2_q;
      2'd1:    sel_term = win1_q;
      default: sel_term = win0_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q    <= IDLE;
      mode_q     <= MODE_FIB2;
      idx_q      <= '0;
      n_q        <= '0;
      win0_q     <= '0;
      win1_q     <= '0;
      win2_q     <= '0;
      data_out_q <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      overflw_q  <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      error_q <= 1'b0;
      unique case (state_q)
        IDLE, DONE: begin
          if (load && req_valid) begin
            state_q    <= RUN;
            mode_q     <= req_mode;
            n_q        <= order;
            data_out_q <= '0;
            done_q     <= 1'b0;
            overflw_q  <= 1'b0;
            if (req_mode == MODE_FIB3) begin
              idx_q  <= Start3;
              win0_q <= data_in_0;
              win1_q <= data_in_1;
              win2_q <= data_in_2;
            end else begin
              idx_q  <= Start2;
              win0_q <= '0;
              win1_q <= data_in_0;
              win2_q <= data_in_1;
            end
          end else if (load) begin
            error_q <= 1'b1;
          end
        end
        RUN: begin
          if (load) error_q <= 1'b1;
          if (finish) begin
            state_q    <= DONE;
            data_out_q <= sel_term;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
          end else if (sum_ovf) begin
            // Report the last term that still fit.
            state_q    <= DONE;
            data_out_q <= win2_q;
            done_q     <= 1'b1;
            busy_q     <= 1'b0;
            overflw_q  <= 1'b1;
          end else begin
            win0_q <= win1_q;
            win1_q <= win2_q;
            win2_q <= sum;
            idx_q  <= idx_q + 1'b1;
            busy_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign data_out = data_out_q;
  assign done     = done_q;
  assign busy     = busy_q;
  assign overflw  = overflw_q;
  assign error    = error_q;

endmodule

// File: tb/tb_fib_seq_gen.sv
module tb_fib_seq_gen;

  logic        clk = 1'b0;
  logic        reset, clear, load;
  logic [1:0]  mode;
  logic [63:0] d0, d1, d2;
  logic [15:0] order;

  logic [63:0] dout64;
  logic        done64, busy64, ovf64, err64;
  logic [7:0]  dout8;
  logic        done8, busy8, ovf8, err8;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  fib_seq_gen #(
    .DATA_WIDTH(64), .ORDER_WIDTH(16), .MAX_ORDER(1000)
  ) dut64 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .mode(mode),
    .data_in_0(d0), .data_in_1(d1), .data_in_2(d2), .order(order),
    .data_out(dout64), .done(done64), .busy(busy64), .overflw(ovf64), .error(err64)
  );

  fib_seq_gen #(
    .DATA_WIDTH(8), .ORDER_WIDTH(16), .MAX_ORDER(1000)
  ) dut8 (
    .clk(clk), .reset(reset), .clear(clear), .load(load), .mode(mode),
    .data_in_0(d0[7:0]), .data_in_1(d1[7:0]), .data_in_2(d2[7:0]), .order(order),
    .data_out(dout8), .done(done8), .busy(busy8), .overflw(ovf8), .error(err8)
  );

  typedef struct {
    logic [1:0]  mode;
    logic [63:0] s0, s1, s2;
    logic [15:0] n;
    logic [63:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a request for one edge (that edge is E0), return at E0 + #1.
  task automatic issue(input logic [1:0] m, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] c, input logic [15:0] n);
    mode = m; d0 = a; d1 = b; d2 = c; order = n; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  // Edges until done on the chosen DUT, with a cycle bound; -1 on timeout.
  task automatic wait_done(input bit use8, input int bound, output int lat,
                           output int busy_cnt, output bit both);
    lat = 0; busy_cnt = 0; both = 1'b0;
    while (!(use8 ? done8 : done64) && lat < bound) begin
      tick();
      lat++;
      if (use8 ? busy8 : busy64) busy_cnt++;
      if (use8 ? (busy8 && done8) : (busy64 && done64)) both = 1'b1;
    end
    if (!(use8 ? done8 : done64)) lat = -1;
  endtask

  task automatic check_zero(input string name);
    check({name, " data"}, dout64, 64'd0);
    check({name, " flags"}, {60'd0, done64, busy64, ovf64, err64}, 64'd0);
  endtask

  initial begin
    int lat, bcnt, lat2, bcnt2;
    bit both;

    vecs[0] = '{2'b00, 64'd0, 64'd1, 64'd0, 16'd10, 64'd55,  10};
    vecs[1] = '{2'b00, 64'd2, 64'd1, 64'd0, 16'd5,  64'd11,  5};
    vecs[2] = '{2'b00, 64'd2, 64'd1, 64'd0, 16'd0,  64'd2,   1};
    vecs[3] = '{2'b01, 64'd0, 64'd0, 64'd1, 16'd7,  64'd13,  6};
    vecs[4] = '{2'b01, 64'd0, 64'd0, 64'd1, 16'd2,  64'd1,   1};
    vecs[5] = '{2'b00, 64'd0, 64'd1, 64'd9, 16'd1,  64'd1,   1};
    vecs[6] = '{2'b01, 64'd1, 64'd1, 64'd1, 16'd4,  64'd5,   3};
    vecs[7] = '{2'b00, 64'd0, 64'd1, 64'd0, 16'd2,  64'd1,   2};
    vecs[8] = '{2'b00, 64'd3, 64'd5, 64'd0, 16'd12, 64'd987, 12};

    reset = 1'b1; clear = 1'b0; load = 1'b0; mode = 2'b00;
    d0 = '0; d1 = '0; d2 = '0; order = '0;
    tick();
    tick();
    check_zero("reset");
    reset = 1'b0;
    tick();

    // Table: first from IDLE, the rest reload straight out of DONE.
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].mode, vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].n);
      wait_done(1'b0, 200, lat, bcnt, both);
      check($sformatf("vec%0d data", i), dout64, vecs[i].exp_data);
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].exp_lat));
      check($sformatf("vec%0d busy cycles", i), 64'(bcnt), 64'(vecs[i].exp_lat - 1));
      check($sformatf("vec%0d busy&done", i), {63'd0, both}, 64'd0);
      check($sformatf("vec%0d ovf/err", i), {62'd0, ovf64, err64}, 64'd0);
    end

    // 8-bit Fibonacci overflows computing x[14]=377; x[13]=233 is reported.
    issue(2'b00, 64'd0, 64'd1, 64'd0, 16'd20);
    wait_done(1'b1, 100, lat, bcnt, both);
    check("ovf8 latency", 64'(lat), 64'd13);
    check("ovf8 data", {56'd0, dout8}, 64'd233);
    check("ovf8 flags", {61'd0, done8, ovf8, busy8}, 64'b110);
    wait_done(1'b0, 100, lat2, bcnt2, both);
    check("fib20 latency", 64'(lat + lat2), 64'd20);
    check("fib20 data", dout64, 64'd6765);
    check("fib20 ovf", {63'd0, ovf64}, 64'd0);

    // order == MAX_ORDER is accepted; 64-bit Fibonacci overflows at x[94].
    issue(2'b00, 64'd0, 64'd1, 64'd0, 16'd1000);
    check("maxorder no error", {63'd0, err64}, 64'd0);
    wait_done(1'b0, 2000, lat, bcnt, both);
    check("ovf64 latency", 64'(lat), 64'd93);
    check("ovf64 data", dout64, 64'd12200160415121876738);
    check("ovf64 flag", {63'd0, ovf64}, 64'd1);

    // Rejected load in DONE: one-cycle error, result and flags held.
    issue(2'b00, 64'd0, 64'd1, 64'd0, 16'd1001);
    check("order>max error", {63'd0, err64}, 64'd1);
    check("order>max held", dout64, 64'd12200160415121876738);
    check("order>max state", {61'd0, done64, ovf64, busy64}, 64'b110);
    tick();
    check("order>max error fall", {63'd0, err64}, 64'd0);

    // Load during RUN is rejected and the original run completes.
    issue(2'b00, 64'd0, 64'd1, 64'd0, 16'd10);
    tick();
    tick();
    issue(2'b00, 64'd2, 64'd1, 64'd0, 16'd3);
    check("run-load error", {63'd0, err64}, 64'd1);
    check("run-load busy", {63'd0, busy64}, 64'd1);
    tick();
    check("run-load error fall", {63'd0, err64}, 64'd0);
    wait_done(1'b0, 100, lat, bcnt, both);
    check("run-load latency", 64'(lat + 4), 64'd10);
    check("run-load data", dout64, 64'd55);

    // clear on cycle 3 of a run.
    issue(2'b00, 64'd0, 64'd1, 64'd0, 16'd10);
    tick();
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_zero("clear mid-run");
    tick(); tick(); tick();
    check_zero("clear idle");

    // Reserved mode from IDLE.
    issue(2'b10, 64'd0, 64'd1, 64'd0, 16'd5);
    check("mode10 error", {63'd0, err64}, 64'd1);
    tick();
    tick();
    check_zero("mode10 idle");

    // clear and load together out of DONE: nothing starts, no error.
    issue(2'b00, 64'd5, 64'd6, 64'd0, 16'd0);
    wait_done(1'b0, 10, lat, bcnt, both);
    check("n0 data", dout64, 64'd5);
    mode = 2'b00; d0 = 64'd0; d1 = 64'd1; order = 16'd10;
    clear = 1'b1; load = 1'b1;
    tick();
    clear = 1'b0; load = 1'b0;
    check_zero("clear+load");
    tick(); tick();
    check_zero("clear+load idle");

    // reset mid-run.
    issue(2'b01, 64'd0, 64'd0, 64'd1, 16'd20);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_zero("reset mid-run");
    tick(); tick();
    check_zero("reset idle");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
